// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster path.
// - Default 640x480@60 timing values (pixels / lines)
// - Renderer color constants ({R,G,B})
// - coord_t: 10-bit raster coordinate
package vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_counter.sv
// Wrap-around raster counter (one per axis).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc_i     - advance the count this cycle
//   cnt_o     - current count, 0..Total-1
//   wrap_o    - high when this cycle's increment wraps Total-1 -> 0
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned Total = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  output logic [9:0] cnt_o,
  output logic       wrap_o
);

  localparam coord_t Last = coord_t'(Total - 1);

  coord_t cnt_q, cnt_d;

  assign wrap_o = inc_i && (cnt_q == Last);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y counters, and an
// output stage that registers rgb/hsync/vsync one pixel period behind (x,y).
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   en           - raster enable; low freezes every register
//   x, y         - current raster position (counter registers)
//   active       - (x,y) lies in the visible area
//   pix_tick     - counters advance on this cycle's closing edge
//   color_in     - renderer color for the current (x,y)
//   hsync, vsync - active-low syncs, aligned with rgb
//   rgb          - color to DAC, black outside the visible area
//   vblank_tick  - one-clk pulse as the raster enters vertical blank
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       pix_tick,
  input  logic [2:0] color_in,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       vblank_tick
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t HActive    = coord_t'(H_ACTIVE);
  localparam coord_t VActive    = coord_t'(V_ACTIVE);
  localparam coord_t HSyncStart = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HSyncEnd   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VSyncStart = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VSyncEnd   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t VLastVis   = coord_t'(V_ACTIVE - 1);
  localparam logic [3:0] DivLast = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vblank_q, vblank_d;

  coord_t x_cnt, y_cnt;
  logic   h_wrap;
  logic   unused_v_wrap;

  // With CLK_DIV == 1 DivLast is 0, so div_q stays 0 and pix_tick == en.
  assign pix_tick = en && !rst && (div_q == DivLast);

  vga_counter #(
    .Total (HTotal)
  ) u_h_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (pix_tick),
    .cnt_o  (x_cnt),
    .wrap_o (h_wrap)
  );

  vga_counter #(
    .Total (VTotal)
  ) u_v_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (h_wrap),
    .cnt_o  (y_cnt),
    .wrap_o (unused_v_wrap)
  );

  assign x      = x_cnt;
  assign y      = y_cnt;
  assign active = (x_cnt < HActive) && (y_cnt < VActive);

  always_comb begin
    div_d   = div_q;
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_tick) begin
      div_d   = '0;
      rgb_d   = active ? color_in : BLACK;
      hsync_d = !((x_cnt >= HSyncStart) && (x_cnt < HSyncEnd));
      vsync_d = !((y_cnt >= VSyncStart) && (y_cnt < VSyncEnd));
    end else if (en) begin
      div_d = div_q + 4'd1;
    end
    // The line wrap out of the last visible line lands on (0, V_ACTIVE).
    vblank_d = h_wrap && (y_cnt == VLastVis);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      rgb_q    <= BLACK;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vblank_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vblank_tick = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800-pixel lines with a shortened 15-line
// frame (8 visible, fp 2, sync 2, bp 3) so two frames fit in a short run.
// u_dut runs at CLK_DIV=2; u_dut1 runs at CLK_DIV=1 with en held high.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       en1;
  logic [2:0] color_in;

  logic [9:0] x, y, x1, y1;
  logic       active, pix_tick, hsync, vsync, vblank_tick;
  logic       active1, pix_tick1, hsync1, vsync1, vblank_tick1;
  logic [2:0] rgb, rgb1;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV (2), .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (8), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) u_dut (
    .clk (clk), .rst (rst), .en (en), .x (x), .y (y), .active (active),
    .pix_tick (pix_tick), .color_in (color_in), .hsync (hsync), .vsync (vsync),
    .rgb (rgb), .vblank_tick (vblank_tick)
  );

  vga_timing_gen #(
    .CLK_DIV (1), .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (8), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) u_dut1 (
    .clk (clk), .rst (rst), .en (en1), .x (x1), .y (y1), .active (active1),
    .pix_tick (pix_tick1), .color_in (color_in), .hsync (hsync1), .vsync (vsync1),
    .rgb (rgb1), .vblank_tick (vblank_tick1)
  );

  typedef struct {
    int unsigned at;
    string       name;
    logic [9:0]  x, y;
    logic        hs, vs;
    logic [2:0]  rgb;
    logic        pt, vb;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned hs_q[$], vs_q[$], vb_q[$], vb1_q[$];
  int unsigned ncnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Expect the state k posedges after the one just passed.
  task automatic exp_at(input int unsigned k, input string name,
                        input int unsigned ex, input int unsigned ey,
                        input logic ehs, input logic evs, input logic [2:0] ergb,
                        input logic ept, input logic evb);
    exp_t e;
    e.at = ncnt + 1 + k; e.name = name; e.x = 10'(ex); e.y = 10'(ey);
    e.hs = ehs; e.vs = evs; e.rgb = ergb; e.pt = ept; e.vb = evb;
    exp_q.push_back(e);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string name, input int sz);
    n_checks++;
    if (sz != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected events never observed, want 0", name, sz);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations as they fall due.
  exp_t        m_e;
  int unsigned hs_run = 0, vs_run = 0, vb_last = 0, vb1_last = 0, want;
  bit          vb_ok = 0, vb1_ok = 0;
  logic        hs_prev = 1'b1, vs_prev = 1'b1, vb_prev = 1'b0, vb1_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      ncnt++;
      while (exp_q.size() > 0 && exp_q[0].at <= ncnt) begin
        m_e = exp_q.pop_front();
        n_checks++;
        if (x !== m_e.x || y !== m_e.y || hsync !== m_e.hs || vsync !== m_e.vs ||
            rgb !== m_e.rgb || pix_tick !== m_e.pt || vblank_tick !== m_e.vb) begin
          n_fail++;
          $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b rgb=%b pt=%b vb=%b, want x=%0d y=%0d hs=%b vs=%b rgb=%b pt=%b vb=%b",
                   m_e.name, x, y, hsync, vsync, rgb, pix_tick, vblank_tick,
                   m_e.x, m_e.y, m_e.hs, m_e.vs, m_e.rgb, m_e.pt, m_e.vb);
        end
      end
      if (rst) begin
        hs_run = 0; vs_run = 0; vb_ok = 0; vb1_ok = 0;
      end else begin
        if (hsync == 1'b0) hs_run++;
        else begin
          if (hs_prev == 1'b0 && hs_q.size() > 0) begin
            want = hs_q.pop_front();
            n_checks++;
            if (hs_run != want) begin
              n_fail++;
              $display("FAIL hsync_width: got %0d clks low, want %0d", hs_run, want);
            end
          end
          hs_run = 0;
        end
        if (vsync == 1'b0) vs_run++;
        else begin
          if (vs_prev == 1'b0 && vs_q.size() > 0) begin
            want = vs_q.pop_front();
            n_checks++;
            if (vs_run != want) begin
              n_fail++;
              $display("FAIL vsync_width: got %0d clks low, want %0d", vs_run, want);
            end
          end
          vs_run = 0;
        end
        if (vblank_tick) begin
          n_checks++;
          if (vb_prev !== 1'b0) begin
            n_fail++;
            $display("FAIL vblank_width: got high on consecutive clks, want 1 clk");
          end
          if (vb_ok && vb_q.size() > 0) begin
            want = vb_q.pop_front();
            n_checks++;
            if (ncnt - vb_last != want) begin
              n_fail++;
              $display("FAIL vblank_period: got %0d clks, want %0d", ncnt - vb_last, want);
            end
          end
          vb_last = ncnt; vb_ok = 1;
        end
        if (vblank_tick1) begin
          n_checks++;
          if (vb1_prev !== 1'b0) begin
            n_fail++;
            $display("FAIL vblank1_width: got high on consecutive clks, want 1 clk");
          end
          if (vb1_ok && vb1_q.size() > 0) begin
            want = vb1_q.pop_front();
            n_checks++;
            if (ncnt - vb1_last != want) begin
              n_fail++;
              $display("FAIL div1_frame_len: got %0d clks, want %0d", ncnt - vb1_last, want);
            end
          end
          vb1_last = ncnt; vb1_ok = 1;
        end
        n_checks++;
        if (pix_tick1 !== 1'b1) begin
          n_fail++;
          $display("FAIL div1_pix_tick: got %b at clk %0d, want 1", pix_tick1, ncnt);
        end
      end
      hs_prev = hsync; vs_prev = vsync; vb_prev = vblank_tick; vb1_prev = vblank_tick1;
    end
  end

  // Stimulus. Field order: x, y, hsync, vsync, rgb, pix_tick, vblank_tick.
  initial begin
    rst = 1'b1; en = 1'b1; en1 = 1'b1; color_in = 3'b100;
    step(3);
    exp_at(0, "reset_hold", 0, 0, 1, 1, 0, 0, 0);
    step(1);
    rst = 1'b0;
    hs_q.push_back(192);
    exp_at(0,    "p1_start",      0,   0, 1, 1, 0, 0, 0);
    exp_at(1,    "p1_first_tick", 0,   0, 1, 1, 0, 1, 0);
    exp_at(2,    "p1_first_px",   1,   0, 1, 1, 4, 0, 0);
    exp_at(1280, "rgb_last_vis",  640, 0, 1, 1, 4, 0, 0);
    exp_at(1282, "rgb_hblank",    641, 0, 1, 1, 0, 0, 0);
    exp_at(1312, "hs_before",     656, 0, 1, 1, 0, 0, 0);
    exp_at(1314, "hs_first_low",  657, 0, 0, 1, 0, 0, 0);
    exp_at(1504, "hs_last_low",   752, 0, 0, 1, 0, 0, 0);
    exp_at(1506, "hs_release",    753, 0, 1, 1, 0, 0, 0);
    exp_at(1599, "x_last",        799, 0, 1, 1, 0, 1, 0);
    exp_at(1600, "x_wrap_y_inc",  0,   1, 1, 1, 0, 0, 0);
    exp_at(1602, "line1_first",   1,   1, 1, 1, 4, 0, 0);
    exp_at(2199, "mid_line",      299, 1, 1, 1, 4, 1, 0);
    step(2200);
    rst = 1'b1;
    exp_at(0, "rst_async", 0, 0, 1, 1, 0, 0, 0);
    exp_at(2, "rst_hold",  0, 0, 1, 1, 0, 0, 0);
    step(3);
    rst = 1'b0;
    hs_q.push_back(192);
    vs_q.push_back(3200);
    vs_q.push_back(3237);
    vb_q.push_back(24000);
    vb_q.push_back(24037);
    repeat (4) vb1_q.push_back(12000);
    exp_at(0,     "r_start",       0,   0,  1, 1, 0, 0, 0);
    exp_at(1,     "r_first_tick",  0,   0,  1, 1, 0, 1, 0);
    exp_at(2,     "r_first_px",    1,   0,  1, 1, 4, 0, 0);
    exp_at(12799, "pre_vblank",    799, 7,  1, 1, 0, 1, 0);
    exp_at(12800, "vblank_tick",   0,   8,  1, 1, 0, 0, 1);
    exp_at(12801, "vblank_end",    0,   8,  1, 1, 0, 1, 0);
    exp_at(12802, "vblank_rgb",    1,   8,  1, 1, 0, 0, 0);
    exp_at(16000, "vs_before",     0,   10, 1, 1, 0, 0, 0);
    exp_at(16002, "vs_first_low",  1,   10, 1, 0, 0, 0, 0);
    exp_at(19200, "vs_last_low",   0,   12, 1, 0, 0, 0, 0);
    exp_at(19202, "vs_release",    1,   12, 1, 1, 0, 0, 0);
    exp_at(23998, "frame_last",    799, 14, 1, 1, 0, 0, 0);
    exp_at(24000, "frame_wrap",    0,   0,  1, 1, 0, 0, 0);
    exp_at(24002, "frame2_first",  1,   0,  1, 1, 4, 0, 0);
    exp_at(36800, "vblank2",       0,   8,  1, 1, 0, 0, 1);
    step(40200);
    en = 1'b0;
    for (int k = 0; k < 37; k++) exp_at(k, "en_gap", 100, 10, 1, 0, 0, 0, 0);
    step(37);
    en = 1'b1;
    exp_at(0,     "en_resume0",  100, 10, 1, 0, 0, 0, 0);
    exp_at(1,     "en_resume1",  100, 10, 1, 0, 0, 1, 0);
    exp_at(2,     "en_resume2",  101, 10, 1, 0, 0, 0, 0);
    exp_at(20600, "vblank3",     0,   8,  1, 1, 0, 0, 1);
    step(20610);
    @(negedge clk);
    check_empty("point_checks", exp_q.size());
    check_empty("hsync_pulses", hs_q.size());
    check_empty("vsync_pulses", vs_q.size());
    check_empty("vblank_pulses", vb_q.size());
    check_empty("div1_frames", vb1_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
